// File: rtl/tamsayi_bolme_birimi.sv
// Tamsayi bolme birimi: 32-bit radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Optional macro BOLME_ERKEN_BITIS_EN: divide-by-zero and signed overflow complete on the accepting edge.
module tamsayi_bolme_birimi (
    input  logic        clk_g,
    input  logic        rst_g,
    input  logic [3:0]  islev_kodu_g,
    input  logic [31:0] islec1_g,
    input  logic [31:0] islec2_g,
    input  logic        hazir_g,
    output logic        bitti_c,
    output logic [31:0] sonuc_c
);
    localparam int unsigned VERI_W  = 32;
    localparam int unsigned SAYAC_W = 5;
    localparam int unsigned KOD_W   = 4;

    typedef enum logic [1:0] {
        BOSTA   = 2'd0,
        HESAPLA = 2'd1,
        BITTI   = 2'd2
    } durum_t;

    durum_t              durum;
    logic [KOD_W-1:0]    islev_r;
    logic [VERI_W-1:0]   islec1_r;
    logic [VERI_W-1:0]   islec2_r;
    logic [SAYAC_W-1:0]  sayac;
    logic [VERI_W-1:0]   bolum;
    logic [VERI_W-1:0]   kalan;

    // Only the exact one-hot codes select signed or remainder behaviour; anything else is DIVU.
    function automatic logic isaretli_mi(input logic [KOD_W-1:0] kod);
        return (kod == 4'h1) || (kod == 4'h4);
    endfunction

    function automatic logic kalan_mi(input logic [KOD_W-1:0] kod);
        return (kod == 4'h4) || (kod == 4'h8);
    endfunction

    function automatic logic [VERI_W-1:0] mutlak(input logic isaretli, input logic [VERI_W-1:0] x);
        return (isaretli && x[VERI_W-1]) ? VERI_W'(-x) : x;
    endfunction

    function automatic logic ozel_mi(input logic [KOD_W-1:0] kod,
                                     input logic [VERI_W-1:0] a,
                                     input logic [VERI_W-1:0] b);
        return (b == '0) ||
               (isaretli_mi(kod) && (a == {1'b1, {(VERI_W-1){1'b0}}}) && (b == '1));
    endfunction

    function automatic logic [VERI_W-1:0] ozel_sonuc(input logic [KOD_W-1:0] kod,
                                                     input logic [VERI_W-1:0] a,
                                                     input logic [VERI_W-1:0] b);
        if (b == '0)
            return kalan_mi(kod) ? a : '1;
        return kalan_mi(kod) ? '0 : {1'b1, {(VERI_W-1){1'b0}}};
    endfunction

    logic                isaretli;
    logic                kalan_islem;
    logic                bolum_negatif;
    logic [VERI_W-1:0]   bolen_mutlak;
    logic [VERI_W:0]     kaydir;
    logic [VERI_W:0]     fark;
    logic [VERI_W-1:0]   yeni_kalan;
    logic [VERI_W-1:0]   yeni_bolum;
    logic [VERI_W-1:0]   bolum_sonuc;
    logic [VERI_W-1:0]   kalan_sonuc;
    logic [VERI_W-1:0]   son_sonuc;

    // One restoring step plus the sign-corrected result of the step that would finish now.
    always_comb begin
        son_sonuc     = '0;
        isaretli      = isaretli_mi(islev_r);
        kalan_islem   = kalan_mi(islev_r);
        bolen_mutlak  = mutlak(isaretli, islec2_r);
        kaydir        = {kalan, bolum[VERI_W-1]};
        fark          = kaydir - {1'b0, bolen_mutlak};
        yeni_kalan    = fark[VERI_W] ? kaydir[VERI_W-1:0] : fark[VERI_W-1:0];
        yeni_bolum    = {bolum[VERI_W-2:0], ~fark[VERI_W]};
        bolum_negatif = isaretli && (islec1_r[VERI_W-1] ^ islec2_r[VERI_W-1]);
        bolum_sonuc   = bolum_negatif ? VERI_W'(-yeni_bolum) : yeni_bolum;
        kalan_sonuc   = (isaretli && islec1_r[VERI_W-1]) ? VERI_W'(-yeni_kalan) : yeni_kalan;
        if (ozel_mi(islev_r, islec1_r, islec2_r))
            son_sonuc = ozel_sonuc(islev_r, islec1_r, islec2_r);
        else
            son_sonuc = kalan_islem ? kalan_sonuc : bolum_sonuc;
    end

    always_ff @(posedge clk_g or negedge rst_g) begin
        if (!rst_g) begin
            durum    <= BOSTA;
            islev_r  <= '0;
            islec1_r <= '0;
            islec2_r <= '0;
            sayac    <= '0;
            bolum    <= '0;
            kalan    <= '0;
            bitti_c  <= 1'b0;
            sonuc_c  <= '0;
        end else begin
            case (durum)
                BOSTA, BITTI: begin
                    bitti_c <= 1'b0;
                    durum   <= BOSTA;
                    if (hazir_g) begin
                        islev_r  <= islev_kodu_g;
                        islec1_r <= islec1_g;
                        islec2_r <= islec2_g;
                        sayac    <= '0;
                        bolum    <= mutlak(isaretli_mi(islev_kodu_g), islec1_g);
                        kalan    <= '0;
`ifdef BOLME_ERKEN_BITIS_EN
                        if (ozel_mi(islev_kodu_g, islec1_g, islec2_g)) begin
                            durum   <= BITTI;
                            bitti_c <= 1'b1;
                            sonuc_c <= ozel_sonuc(islev_kodu_g, islec1_g, islec2_g);
                        end else begin
                            durum   <= HESAPLA;
                        end
`else
                        durum    <= HESAPLA;
`endif
                    end
                end
                HESAPLA: begin
                    bolum <= yeni_bolum;
                    kalan <= yeni_kalan;
                    sayac <= sayac + SAYAC_W'(1);
                    if (sayac == SAYAC_W'(VERI_W - 1)) begin
                        durum   <= BITTI;
                        bitti_c <= 1'b1;
                        sonuc_c <= son_sonuc;
                    end
                end
                default: begin
                    durum   <= BOSTA;
                    bitti_c <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tamsayi_bolme_birimi.sv
// Bench for tamsayi_bolme_birimi: scoreboard of expected results, one task per scenario.
module tb_tamsayi_bolme_birimi;
    logic        clk_g = 1'b0;
    logic        rst_g;
    logic [3:0]  islev_kodu_g;
    logic [31:0] islec1_g;
    logic [31:0] islec2_g;
    logic        hazir_g;
    logic        bitti_c;
    logic [31:0] sonuc_c;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [31:0] deger;
        int          gecikme;
    } beklenen_t;

    beklenen_t sb[$];

`ifdef BOLME_ERKEN_BITIS_EN
    localparam int OZEL_GECIKME = 1;
`else
    localparam int OZEL_GECIKME = 33;
`endif

    tamsayi_bolme_birimi dut (
        .clk_g        (clk_g),
        .rst_g        (rst_g),
        .islev_kodu_g (islev_kodu_g),
        .islec1_g     (islec1_g),
        .islec2_g     (islec2_g),
        .hazir_g      (hazir_g),
        .bitti_c      (bitti_c),
        .sonuc_c      (sonuc_c)
    );

    always #5 clk_g = ~clk_g;

    function automatic logic ozel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        sgn = (op == 4'h1) || (op == 4'h4);
        return (b == 32'h0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Reference using the simulator's own 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic   sgn;
        logic   rem;
        longint sa;
        longint sbv;
        longint q;
        longint r;
        sgn = (op == 4'h1) || (op == 4'h4);
        rem = (op == 4'h4) || (op == 4'h8);
        if (b == 32'h0) return rem ? a : 32'hFFFF_FFFF;
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
            q   = sa / sbv;
            r   = sa % sbv;
            return rem ? r[31:0] : q[31:0];
        end
        return rem ? (a % b) : (a / b);
    endfunction

    // Caller sits at a negedge; the following posedge accepts the request.
    task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] beklenen);
        beklenen_t e;
        e.deger   = beklenen;
        e.gecikme = ozel(op, a, b) ? OZEL_GECIKME : 33;
        sb.push_back(e);
        islev_kodu_g = op;
        islec1_g     = a;
        islec2_g     = b;
        hazir_g      = 1'b1;
        @(negedge clk_g);
        hazir_g      = 1'b0;
    endtask

    // Latency counts edges with the accepting edge as 1; capped so a silent DUT cannot hang the run.
    task automatic wait_done(output logic [31:0] res, output int lat);
        lat = 1;
        while (bitti_c !== 1'b1 && lat < 100) begin
            @(negedge clk_g);
            lat++;
        end
        res = sonuc_c;
    endtask

    task automatic do_one(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] beklenen,
                          output logic [31:0] res, output int lat, output beklenen_t e);
        @(negedge clk_g);
        start_op(op, a, b, beklenen);
        wait_done(res, lat);
        e = sb.pop_front();
    endtask

    task automatic test_reset;
        rst_g        = 1'b1;
        hazir_g      = 1'b0;
        islev_kodu_g = 4'h0;
        islec1_g     = 32'h0;
        islec2_g     = 32'h0;
        #2 rst_g = 1'b0;
        #1;
        tests++;
        if (bitti_c !== 1'b0) begin failed++; $display("FAIL reset_bitti: got %b expected 0", bitti_c); end
        tests++;
        if (sonuc_c !== 32'h0) begin failed++; $display("FAIL reset_sonuc: got %h expected 00000000", sonuc_c); end
        @(negedge clk_g);
        rst_g = 1'b1;
    endtask

    task automatic test_signed;
        logic [3:0]  ops  [2] = '{4'h1, 4'h4};
        logic [31:0] exps [2] = '{32'hFFFF_FFFA, 32'h0000_0002};
        logic [31:0] res;
        int          lat;
        beklenen_t   e;
        for (int i = 0; i < 2; i++) begin
            do_one(ops[i], 32'd20, 32'hFFFF_FFFD, exps[i], res, lat, e);
            tests++;
            if (res !== e.deger) begin failed++; $display("FAIL signed[%0d] result: got %h expected %h", i, res, e.deger); end
            tests++;
            if (lat != e.gecikme) begin failed++; $display("FAIL signed[%0d] latency: got %0d expected %0d", i, lat, e.gecikme); end
            @(negedge clk_g);
            tests++;
            if (bitti_c !== 1'b0) begin failed++; $display("FAIL signed[%0d] pulse_width: bitti_c got %b expected 0", i, bitti_c); end
        end
    endtask

    task automatic test_unsigned;
        logic [3:0]  ops [5] = '{4'h2, 4'h8, 4'h4, 4'h3, 4'hC};
        logic [31:0] as  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF0, 32'd100};
        logic [31:0] bs  [5] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd7};
        logic [31:0] exps[5] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFF8, 32'h0000_000E};
        logic [31:0] res;
        int          lat;
        beklenen_t   e;
        for (int i = 0; i < 5; i++) begin
            do_one(ops[i], as[i], bs[i], exps[i], res, lat, e);
            tests++;
            if (res !== e.deger) begin failed++; $display("FAIL unsigned[%0d] result: got %h expected %h", i, res, e.deger); end
            tests++;
            if (lat != e.gecikme) begin failed++; $display("FAIL unsigned[%0d] latency: got %0d expected %0d", i, lat, e.gecikme); end
        end
    endtask

    task automatic test_special;
        logic [3:0]  ops [6] = '{4'h2, 4'h8, 4'h1, 4'h4, 4'h1, 4'h4};
        logic [31:0] as  [6] = '{32'd5, 32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exps[6] = '{32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFB,
                                 32'h8000_0000, 32'h0000_0000};
        logic [31:0] res;
        int          lat;
        beklenen_t   e;
        for (int i = 0; i < 6; i++) begin
            do_one(ops[i], as[i], bs[i], exps[i], res, lat, e);
            tests++;
            if (res !== e.deger) begin failed++; $display("FAIL special[%0d] result: got %h expected %h", i, res, e.deger); end
            tests++;
            if (lat != e.gecikme) begin failed++; $display("FAIL special[%0d] latency: got %0d expected %0d", i, lat, e.gecikme); end
            @(negedge clk_g);
            tests++;
            if (bitti_c !== 1'b0) begin failed++; $display("FAIL special[%0d] pulse_width: bitti_c got %b expected 0", i, bitti_c); end
        end
    endtask

    task automatic test_random;
        logic [3:0]  ops [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        beklenen_t   e;
        for (int i = 0; i < 10; i++) begin
            op = ops[$urandom_range(0, 3)];
            a  = $urandom >> $urandom_range(0, 20);
            if ($urandom_range(0, 1) == 1) a = -a;
            b  = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) b = -b;
            do_one(op, a, b, model(op, a, b), res, lat, e);
            tests++;
            if (res !== e.deger) begin
                failed++;
                $display("FAIL random[%0d] op=%h a=%h b=%h: got %h expected %h", i, op, a, b, res, e.deger);
            end
            tests++;
            if (lat != e.gecikme) begin failed++; $display("FAIL random[%0d] latency: got %0d expected %0d", i, lat, e.gecikme); end
        end
    endtask

    task automatic test_ignore_midway;
        logic [31:0] res;
        int          lat;
        beklenen_t   e;
        @(negedge clk_g);
        start_op(4'h2, 32'h1234_5678, 32'h10, 32'h0123_4567);
        repeat (5) @(negedge clk_g);
        islev_kodu_g = 4'h4;
        islec1_g     = 32'd7;
        islec2_g     = 32'd3;
        hazir_g      = 1'b1;
        @(negedge clk_g);
        hazir_g      = 1'b0;
        wait_done(res, lat);
        e = sb.pop_front();
        tests++;
        if (res !== e.deger) begin failed++; $display("FAIL ignore_midway result: got %h expected %h", res, e.deger); end
        tests++;
        if (lat + 6 != e.gecikme) begin failed++; $display("FAIL ignore_midway latency: got %0d expected %0d", lat + 6, e.gecikme); end
        @(negedge clk_g);
        tests++;
        if (bitti_c !== 1'b0) begin failed++; $display("FAIL ignore_midway extra_pulse: bitti_c got %b expected 0", bitti_c); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] res;
        int          lat;
        int          degisen;
        beklenen_t   e;
        do_one(4'h2, 32'd1000, 32'd10, 32'd100, res, lat, e);
        tests++;
        if (res !== e.deger) begin failed++; $display("FAIL b2b_first result: got %h expected %h", res, e.deger); end
        start_op(4'h1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
        wait_done(res, lat);
        e = sb.pop_front();
        tests++;
        if (res !== e.deger) begin failed++; $display("FAIL b2b_second result: got %h expected %h", res, e.deger); end
        tests++;
        if (lat != e.gecikme) begin failed++; $display("FAIL b2b_second latency: got %0d expected %0d", lat, e.gecikme); end
        degisen = 0;
        repeat (6) begin
            @(negedge clk_g);
            if (sonuc_c !== e.deger) degisen++;
        end
        tests++;
        if (degisen != 0) begin failed++; $display("FAIL hold_result: %0d cycles differed, expected 0 (last %h, want %h)", degisen, sonuc_c, e.deger); end
    endtask

    task automatic test_reset_midway;
        logic [31:0] res;
        int          lat;
        int          darbe;
        beklenen_t   e;
        @(negedge clk_g);
        start_op(4'h2, 32'd1000, 32'd3, 32'd333);
        repeat (10) @(negedge clk_g);
        #1 rst_g = 1'b0;
        #1;
        tests++;
        if (bitti_c !== 1'b0) begin failed++; $display("FAIL midreset_bitti: got %b expected 0", bitti_c); end
        tests++;
        if (sonuc_c !== 32'h0) begin failed++; $display("FAIL midreset_sonuc: got %h expected 00000000", sonuc_c); end
        sb.delete();
        @(negedge clk_g);
        rst_g = 1'b1;
        darbe = 0;
        repeat (40) begin
            @(negedge clk_g);
            if (bitti_c !== 1'b0) darbe++;
        end
        tests++;
        if (darbe != 0) begin failed++; $display("FAIL midreset_no_pulse: got %0d pulse cycles expected 0", darbe); end
        // Request is already pending while reset releases, so the first edge after release accepts it.
        @(negedge clk_g);
        rst_g = 1'b0;
        e.deger   = 32'h0000_000E;
        e.gecikme = 33;
        sb.push_back(e);
        islev_kodu_g = 4'h2;
        islec1_g     = 32'd100;
        islec2_g     = 32'd7;
        hazir_g      = 1'b1;
        @(negedge clk_g);
        rst_g = 1'b1;
        @(negedge clk_g);
        hazir_g = 1'b0;
        wait_done(res, lat);
        e = sb.pop_front();
        tests++;
        if (res !== e.deger) begin failed++; $display("FAIL after_reset result: got %h expected %h", res, e.deger); end
        tests++;
        if (lat != e.gecikme) begin failed++; $display("FAIL after_reset latency: got %0d expected %0d", lat, e.gecikme); end
    endtask

    initial begin
        test_reset();
        test_signed();
        test_unsigned();
        test_special();
        test_random();
        test_ignore_midway();
        test_back_to_back();
        test_reset_midway();
        tests++;
        if (sb.size() != 0) begin failed++; $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
